// File: rtl/regbank_pkg.sv
// rtl/regbank_pkg.sv - shared widths, types and helpers for the regbank_v4 register file
package regbank_pkg;

  localparam int DATA_W   = 32;
  localparam int ADDR_W   = 5;
  localparam int NUM_REGS = 32;

  typedef logic [ADDR_W-1:0] reg_addr_t;
  typedef logic [DATA_W-1:0] reg_data_t;

  // True when a read address targets the register being written this cycle
  function automatic logic bypass_hit(input logic wr, input reg_addr_t rd_addr,
                                      input reg_addr_t wr_addr);
    return wr && (rd_addr == wr_addr);
  endfunction

endpackage

// File: rtl/regbank_rd_port.sv
// rtl/regbank_rd_port.sv - one combinational read port; WR_BYPASS_EN adds write-data forwarding
module regbank_rd_port
  import regbank_pkg::*;
(
  input  logic [DATA_W-1:0] regs_i [NUM_REGS],
  input  logic [ADDR_W-1:0] addr_i,
  input  logic              rst_n_i,
  input  logic              wr_i,
  input  logic [ADDR_W-1:0] dr_i,
  input  logic [DATA_W-1:0] wr_data_i,
  output logic [DATA_W-1:0] rd_data_o
);

  logic [DATA_W-1:0] stored;

  assign stored = regs_i[addr_i];

`ifdef WR_BYPASS_EN
  always_comb begin
    rd_data_o = '0;
    if (rst_n_i) begin
      rd_data_o = bypass_hit(wr_i, addr_i, dr_i) ? wr_data_i : stored;
    end
  end
`else
  logic unused_bypass;
  assign unused_bypass = ^{wr_i, dr_i, wr_data_i};

  // Storage is already cleared during reset; the gate also covers the reset-assert instant
  always_comb begin
    rd_data_o = '0;
    if (rst_n_i) begin
      rd_data_o = stored;
    end
  end
`endif

endmodule

// File: rtl/regbank_v4.sv
// rtl/regbank_v4.sv - 32x32 register bank, two async read ports, one sync write port (option: WR_BYPASS_EN)
module regbank_v4
  import regbank_pkg::*;
(
  output logic [DATA_W-1:0] rdData1,
  output logic [DATA_W-1:0] rdData2,
  input  logic [DATA_W-1:0] wrData,
  input  logic [ADDR_W-1:0] sr1,
  input  logic [ADDR_W-1:0] sr2,
  input  logic [ADDR_W-1:0] dr,
  input  logic              wr,
  input  logic              clk,
  input  logic              rst
);

  logic [DATA_W-1:0] regs_q [NUM_REGS];
  logic [DATA_W-1:0] regs_d [NUM_REGS];

  always_comb begin
    regs_d = regs_q;
    if (wr) begin
      regs_d[dr] = wrData;
    end
  end

  // Reset is asynchronous and dominates any write landing on the same edge
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        regs_q[i] <= '0;
      end
    end else begin
      regs_q <= regs_d;
    end
  end

  regbank_rd_port u_rd_port1 (
    .regs_i    (regs_q),
    .addr_i    (sr1),
    .rst_n_i   (rst),
    .wr_i      (wr),
    .dr_i      (dr),
    .wr_data_i (wrData),
    .rd_data_o (rdData1)
  );

  regbank_rd_port u_rd_port2 (
    .regs_i    (regs_q),
    .addr_i    (sr2),
    .rst_n_i   (rst),
    .wr_i      (wr),
    .dr_i      (dr),
    .wr_data_i (wrData),
    .rd_data_o (rdData2)
  );

endmodule

// File: tb/tb_regbank_v4.sv
// tb/tb_regbank_v4.sv - randomized model-checked bench for regbank_v4 (honours WR_BYPASS_EN)
`timescale 1ns/1ps
module tb_regbank_v4;

  logic [31:0] rdData1, rdData2, wrData;
  logic [4:0]  sr1, sr2, dr;
  logic        wr, clk, rst;

  int n_cmp = 0;
  int n_bad = 0;
  logic [31:0] model [32];

  regbank_v4 dut (
    .rdData1 (rdData1),
    .rdData2 (rdData2),
    .wrData  (wrData),
    .sr1     (sr1),
    .sr2     (sr2),
    .dr      (dr),
    .wr      (wr),
    .clk     (clk),
    .rst     (rst)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %08h expected %08h at %0t", name, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] expect_rd(input logic [4:0] sa);
    if (rst !== 1'b1) return 32'h0;
`ifdef WR_BYPASS_EN
    if (wr && sa == dr) return wrData;
`endif
    return model[sa];
  endfunction

  // Reference contents: cleared whenever reset falls, written on a clean rising edge
  always @(negedge rst) begin
    for (int i = 0; i < 32; i++) model[i] = 32'h0;
  end
  always @(posedge clk) begin
    if (rst === 1'b1 && wr === 1'b1) model[dr] = wrData;
  end

  always @(negedge clk) begin
    check("cyc_rd1", rdData1, expect_rd(sr1));
    check("cyc_rd2", rdData2, expect_rd(sr2));
  end

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  initial begin
    for (int i = 0; i < 32; i++) model[i] = 32'h0;
    rst = 1'b0; wr = 1'b0; dr = 5'd3; wrData = 32'h0; sr1 = 5'd0; sr2 = 5'd0;

    // 1. reset held: every address reads zero
    for (int k = 0; k < 32; k++) begin
      sr1 = 5'(k); sr2 = 5'(31 - k);
      #0.1;
      check("rst_rd1", rdData1, 32'h0);
      check("rst_rd2", rdData2, 32'h0);
    end
    next_cycle();
    rst = 1'b1;
    #1;
    check("rst_rel_rd1", rdData1, 32'h0);
    check("rst_rel_rd2", rdData2, 32'h0);

    // 2. write all entries with 10*k
    for (int k = 0; k < 32; k++) begin
      next_cycle();
      dr = 5'(k); wrData = 32'(10 * k); wr = 1'b1;
      sr1 = 5'(k); sr2 = 5'((k + 1) % 32);
    end
    next_cycle();
    wr = 1'b0;
    for (int k = 0; k < 32; k += 2) begin
      sr1 = 5'(k); sr2 = 5'(k + 1);
      #1;
      check("wall_rd1", rdData1, 32'(10 * k));
      check("wall_rd2", rdData2, 32'(10 * (k + 1)));
    end
    sr1 = 5'd30; sr2 = 5'd31;
    #1;
    check("reg30", rdData1, 32'd300);
    check("reg31", rdData2, 32'd310);

    // 3. write disabled
    wr = 1'b0; dr = 5'd3; wrData = 32'hDEADBEEF; sr1 = 5'd3;
    repeat (4) next_cycle();
    check("wr_off_reg3", rdData1, 32'd30);

    // 4. same-address reads and read-during-write
    sr1 = 5'd7; sr2 = 5'd7;
    #1;
    check("same_rd1", rdData1, 32'd70);
    check("same_rd2", rdData2, 32'd70);
    next_cycle();
    wr = 1'b1; dr = 5'd7; wrData = 32'hA5A5A5A5;
    #1;
`ifdef WR_BYPASS_EN
    check("rdw_pre_edge", rdData1, 32'hA5A5A5A5);
`else
    check("rdw_pre_edge", rdData1, 32'd70);
`endif
    next_cycle();
    wr = 1'b0;
    #1;
    check("rdw_post_edge", rdData1, 32'hA5A5A5A5);
    check("rdw_post_edge2", rdData2, 32'hA5A5A5A5);

    // 5. async reset between edges with a write pending
    next_cycle();
    wr = 1'b1; dr = 5'd5; wrData = 32'h12345678; sr1 = 5'd5; sr2 = 5'd7;
    #1;
    rst = 1'b0;
    #0.5;
    check("arst_rd1", rdData1, 32'h0);
    check("arst_rd2", rdData2, 32'h0);
    next_cycle();
    check("arst_hold", rdData1, 32'h0);
    wr = 1'b0; rst = 1'b1;
    for (int k = 0; k < 32; k++) begin
      sr1 = 5'(k);
      #0.1;
      check("arst_after", rdData1, 32'h0);
    end

    // 6. register 0 is writable
    next_cycle();
    wr = 1'b1; dr = 5'd0; wrData = 32'hFFFFFFFF;
    next_cycle();
    wr = 1'b0; sr1 = 5'd0;
    #1;
    check("reg0", rdData1, 32'hFFFFFFFF);

    // Random traffic with occasional reset pulses; the compare process checks each cycle
    for (int i = 0; i < 2000; i++) begin
      next_cycle();
      rst    = ($urandom_range(0, 199) == 0) ? 1'b0 : 1'b1;
      wr     = $urandom_range(0, 1) == 1;
      dr     = 5'($urandom_range(0, 31));
      wrData = $urandom;
      sr1    = ($urandom_range(0, 3) == 0) ? dr : 5'($urandom_range(0, 31));
      sr2    = ($urandom_range(0, 3) == 0) ? sr1 : 5'($urandom_range(0, 31));
    end
    next_cycle();
    rst = 1'b1; wr = 1'b0;
    next_cycle();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
